hpdcache_req_arbiter: RTL and testbench

Shares the single HPDcache core request port among `NREQ` requesters (instruction fetch, load/store, UART DMA). Arbitration is round-robin, with a per-requester outstanding-response credit limit. The block tracks the one-cycle-late physical tag, PMA and abort phase of each granted request. Responses are routed back to the owning requester by source ID. It sits between the requester ports and the `hpdcache_wrapper` core port, which is configured with `nRequesters = 1`.

---
 rtl/hpdcache_req_arbiter.sv | 116 +++++++++++
 tb/tb_hpdcache_req_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_req_arbiter.sv
// hpdcache_req_arbiter: round-robin arbiter sharing one HPDcache core port among NREQ requesters.
// Ports: clk_i/rst_i (sync, active-high); req_* per-requester request, tag-phase and response-valid
// signals; cache_req_* muxed request toward the cache (tag/pma/abort one cycle after acceptance);
// cache_rsp_* response from the cache, routed back by SID; err_o sticky error (bad SID or underflow).
module hpdcache_req_arbiter #(
    parameter int NREQ    = 3,
    parameter int REQ_W   = 128,
    parameter int SID_W   = 3,
    parameter int TAG_W   = 20,
    parameter int PMA_W   = 2,
    parameter int RSP_W   = 40,
    parameter int MAX_OUT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ*REQ_W-1:0] req_i,
    input  logic [NREQ-1:0]       req_need_rsp_i,
    input  logic [NREQ*TAG_W-1:0] req_tag_i,
    input  logic [NREQ*PMA_W-1:0] req_pma_i,
    input  logic [NREQ-1:0]       req_abort_i,
    output logic [NREQ-1:0]       rsp_valid_o,
    output logic [RSP_W-1:0]      rsp_o,
    output logic                  cache_req_valid_o,
    input  logic                  cache_req_ready_i,
    output logic [REQ_W-1:0]      cache_req_o,
    output logic [SID_W-1:0]      cache_req_sid_o,
    output logic                  cache_req_need_rsp_o,
    output logic [TAG_W-1:0]      cache_req_tag_o,
    output logic [PMA_W-1:0]      cache_req_pma_o,
    output logic                  cache_req_abort_o,
    input  logic                  cache_rsp_valid_i,
    input  logic [SID_W-1:0]      cache_rsp_sid_i,
    input  logic [RSP_W-1:0]      cache_rsp_i,
    output logic                  err_o
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_OUT);

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] uf;
    logic [IW-1:0]   gnt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   lock_idx;
    logic [IW-1:0]   s1_idx;
    logic            lock;
    logic            s1_valid;
    logic            s1_need;
    logic            acc;
    logic            bad_sid;
    logic [CW-1:0]   cnt     [NREQ];
    logic [CW-1:0]   cnt_nxt [NREQ];

    // Descending search so the candidate closest to rr_ptr is written last and wins.
    always_comb begin
        elig = '0;
        gnt  = '0;
        for (int i = 0; i < NREQ; i++) elig[i] = req_valid_i[i] && (cnt[i] < MAXC);
        for (int k = NREQ - 1; k >= 0; k--)
            if (elig[(int'(rr_ptr) + k) % NREQ]) gnt = IW'((int'(rr_ptr) + k) % NREQ);
        if (lock) gnt = lock_idx;
    end

    assign cache_req_valid_o    = |elig;
    assign acc                  = cache_req_valid_o && cache_req_ready_i;
    assign req_ready_o          = acc ? NREQ'(1) << gnt : '0;
    assign cache_req_o          = req_i[gnt*REQ_W +: REQ_W];
    assign cache_req_need_rsp_o = req_need_rsp_i[gnt];
    assign cache_req_sid_o      = SID_W'(gnt);
    assign cache_req_tag_o      = s1_valid ? req_tag_i[s1_idx*TAG_W +: TAG_W] : '0;
    assign cache_req_pma_o      = s1_valid ? req_pma_i[s1_idx*PMA_W +: PMA_W] : '0;
    assign cache_req_abort_o    = s1_valid && req_abort_i[s1_idx];
    assign bad_sid              = cache_rsp_valid_i && !(32'(cache_rsp_sid_i) < NREQ);
    assign rsp_valid_o          = (cache_rsp_valid_i && !bad_sid) ? NREQ'(1) << cache_rsp_sid_i : '0;
    assign rsp_o                = cache_rsp_i;

    // Net counter update: +issue, -refunded abort, -response; saturates at zero on underflow.
    always_comb begin
        logic [CW:0] up;
        logic [CW:0] dn;
        up = '0;
        dn = '0;
        uf = '0;
        for (int i = 0; i < NREQ; i++) begin
            up = {1'b0, cnt[i]} + (CW+1)'(acc && 32'(gnt) == i && cache_req_need_rsp_o);
            dn = (CW+1)'(s1_valid && s1_need && req_abort_i[i] && 32'(s1_idx) == i)
               + (CW+1)'(rsp_valid_o[i]);
            uf[i] = up < dn;
            cnt_nxt[i] = uf[i] ? '0 : CW'(up - dn);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_need  <= 1'b0;
            err_o    <= 1'b0;
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else begin
            lock     <= cache_req_valid_o && !cache_req_ready_i;
            lock_idx <= gnt;
            s1_valid <= acc;
            s1_idx   <= gnt;
            s1_need  <= cache_req_need_rsp_o;
            err_o    <= err_o || bad_sid || (|uf);
            if (acc) rr_ptr <= (32'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
            for (int i = 0; i < NREQ; i++) cnt[i] <= cnt_nxt[i];
        end
    end
endmodule

// File: tb/tb_hpdcache_req_arbiter.sv
// tb_hpdcache_req_arbiter: directed self-checking bench for hpdcache_req_arbiter.
module tb_hpdcache_req_arbiter;
    localparam int NREQ = 3, REQ_W = 128, SID_W = 3, TAG_W = 20, PMA_W = 2, RSP_W = 40, MAX_OUT = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*REQ_W-1:0] req = '0;
    logic [NREQ-1:0]       req_need_rsp = '0;
    logic [NREQ*TAG_W-1:0] req_tag = '0;
    logic [NREQ*PMA_W-1:0] req_pma = '0;
    logic [NREQ-1:0]       req_abort = '0;
    logic [NREQ-1:0]       rsp_valid;
    logic [RSP_W-1:0]      rsp;
    logic                  cache_req_valid;
    logic                  cache_req_ready = 1'b0;
    logic [REQ_W-1:0]      cache_req;
    logic [SID_W-1:0]      cache_req_sid;
    logic                  cache_req_need_rsp;
    logic [TAG_W-1:0]      cache_req_tag;
    logic [PMA_W-1:0]      cache_req_pma;
    logic                  cache_req_abort;
    logic                  cache_rsp_valid = 1'b0;
    logic [SID_W-1:0]      cache_rsp_sid = '0;
    logic [RSP_W-1:0]      cache_rsp = '0;
    logic                  err;
    int                    checks = 0;
    int                    fails = 0;

    hpdcache_req_arbiter #(.NREQ(NREQ), .REQ_W(REQ_W), .SID_W(SID_W), .TAG_W(TAG_W),
                           .PMA_W(PMA_W), .RSP_W(RSP_W), .MAX_OUT(MAX_OUT)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_i(req), .req_need_rsp_i(req_need_rsp), .req_tag_i(req_tag), .req_pma_i(req_pma),
        .req_abort_i(req_abort), .rsp_valid_o(rsp_valid), .rsp_o(rsp),
        .cache_req_valid_o(cache_req_valid), .cache_req_ready_i(cache_req_ready),
        .cache_req_o(cache_req), .cache_req_sid_o(cache_req_sid),
        .cache_req_need_rsp_o(cache_req_need_rsp), .cache_req_tag_o(cache_req_tag),
        .cache_req_pma_o(cache_req_pma), .cache_req_abort_o(cache_req_abort),
        .cache_rsp_valid_i(cache_rsp_valid), .cache_rsp_sid_i(cache_rsp_sid),
        .cache_rsp_i(cache_rsp), .err_o(err)
    );

    always #5 clk = ~clk;

    function automatic logic [REQ_W-1:0] pl(input int i);
        return REQ_W'(32'hC0DE_0000 + 32'(i));
    endfunction
    function automatic logic [TAG_W-1:0] tg(input int i);
        return TAG_W'(32'h1000 + 32'(i));
    endfunction
    function automatic logic [PMA_W-1:0] pm(input int i);
        return PMA_W'(i + 1);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            req[i*REQ_W +: REQ_W]     = pl(i);
            req_tag[i*TAG_W +: TAG_W] = tg(i);
            req_pma[i*PMA_W +: PMA_W] = pm(i);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_cvalid", cache_req_valid, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_tag", cache_req_tag, 0);
        chk("rst_pma", cache_req_pma, 0);
        chk("rst_abort", cache_req_abort, 0);
        chk("rst_err", err, 0);

        cache_req_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            req_valid = 3'b111;
            #1;
            chk("rr_sid", cache_req_sid, n % 3);
            chk("rr_ready", req_ready, 1 << (n % 3));
            chk("rr_payload", cache_req, pl(n % 3));
            if (n > 0) begin
                chk("rr_tag", cache_req_tag, tg((n - 1) % 3));
                chk("rr_pma", cache_req_pma, pm((n - 1) % 3));
            end
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("rr_tag_last", cache_req_tag, tg(2));
        chk("rr_idle_valid", cache_req_valid, 0);
        @(negedge clk);
        #1;
        chk("rr_tag_idle", cache_req_tag, 0);

        @(negedge clk);
        cache_req_ready = 1'b0;
        req_valid = 3'b010;
        #1;
        chk("lock_sid1", cache_req_sid, 1);
        chk("lock_noready", req_ready, 0);
        @(negedge clk);
        req_valid = 3'b011;
        #1;
        chk("lock_hold_sid", cache_req_sid, 1);
        chk("lock_hold_ready", req_ready, 0);
        @(negedge clk);
        cache_req_ready = 1'b1;
        #1;
        chk("lock_acc1", req_ready, 3'b010);
        @(negedge clk);
        req_valid = 3'b001;
        #1;
        chk("lock_acc0", req_ready, 3'b001);
        @(negedge clk);
        req_valid = '0;

        req_need_rsp = 3'b100;
        req_valid = 3'b100;
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("credit_acc", req_ready, 3'b100);
            @(negedge clk);
        end
        #1;
        chk("credit_full_ready", req_ready, 0);
        chk("credit_full_valid", cache_req_valid, 0);
        chk("credit_cnt", dut.cnt[2], 4);
        @(negedge clk);
        cache_rsp_valid = 1'b1;
        cache_rsp_sid = 3'd2;
        cache_rsp = 40'hAB_CDEF_0123;
        #1;
        chk("credit_rspv", rsp_valid, 3'b100);
        chk("credit_rsp", rsp, 40'hAB_CDEF_0123);
        chk("credit_nobypass", req_ready, 0);
        @(negedge clk);
        cache_rsp_valid = 1'b0;
        #1;
        chk("credit_5th", req_ready, 3'b100);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("credit_cnt_after", dut.cnt[2], 4);

        @(negedge clk);
        req_valid = 3'b001;
        req_need_rsp = 3'b001;
        #1;
        chk("abort_acc", req_ready, 3'b001);
        @(negedge clk);
        req_valid = '0;
        req_abort = 3'b001;
        #1;
        chk("abort_out", cache_req_abort, 1);
        chk("abort_cnt_pre", dut.cnt[0], 1);
        @(negedge clk);
        req_abort = '0;
        #1;
        chk("abort_cnt_post", dut.cnt[0], 0);
        chk("abort_out_clr", cache_req_abort, 0);

        @(negedge clk);
        req_valid = 3'b010;
        req_need_rsp = 3'b010;
        #1;
        chk("sim_acc_a", req_ready, 3'b010);
        @(negedge clk);
        req_abort = 3'b010;
        cache_rsp_valid = 1'b1;
        cache_rsp_sid = 3'd1;
        #1;
        chk("sim_acc_b", req_ready, 3'b010);
        chk("sim_rspv", rsp_valid, 3'b010);
        chk("sim_abort", cache_req_abort, 1);
        chk("sim_cnt_pre", dut.cnt[1], 1);
        @(negedge clk);
        req_valid = '0;
        req_abort = '0;
        cache_rsp_valid = 1'b0;
        #1;
        chk("sim_cnt_post", dut.cnt[1], 0);
        chk("sim_err", err, 0);

        @(negedge clk);
        cache_rsp_valid = 1'b1;
        cache_rsp_sid = 3'd5;
        #1;
        chk("bad_rspv", rsp_valid, 0);
        @(negedge clk);
        cache_rsp_valid = 1'b0;
        #1;
        chk("bad_err", err, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("bad_err_sticky", err, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("bad_err_rst", err, 0);

        @(negedge clk);
        cache_rsp_valid = 1'b1;
        cache_rsp_sid = 3'd0;
        #1;
        chk("uf_rspv", rsp_valid, 3'b001);
        @(negedge clk);
        cache_rsp_valid = 1'b0;
        #1;
        chk("uf_err", err, 1);
        chk("uf_cnt", dut.cnt[0], 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        req_need_rsp = '0;
        cache_req_ready = 1'b0;
        req_valid = 3'b001;
        #1;
        chk("mid_sid0", cache_req_sid, 0);
        @(negedge clk);
        rst = 1'b1;
        cache_req_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cache_req_ready = 1'b0;
        req_valid = 3'b110;
        #1;
        chk("mid_tag", cache_req_tag, 0);
        chk("mid_nolock", cache_req_sid, 1);
        @(negedge clk);
        req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
